// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for a router input port.
//
// The host loads payload bytes into an internal FIFO and then pulses start
// with a destination and a length. The block sends a header byte
// {len,dest}, then len payload bytes popped from the FIFO, then a parity
// byte. The parity byte is the XOR of the header and every payload byte.
// After the parity byte it forces GAP_CYCLES idle cycles before it accepts
// the next start. While the router holds busy high, the byte on data_out is
// not consumed and is held.
//
// Ports
//   clock, reset    system clock; synchronous active-high reset
//   wr_en, wr_data  host write into the payload FIFO (dropped when full)
//   fifo_full       FIFO holds DEPTH bytes
//   fifo_count      number of bytes in the FIFO
//   start           1-cycle launch request; dest/len are sampled with it
//   dest, len       destination address and payload length (1..63)
//   start_err       1-cycle pulse: start rejected (len=0 or too few bytes)
//   busy            router stall; the current byte is held
//   data_out        byte to the router
//   pkt_valid       high for the header and payload bytes, low for parity
//   tx_active       high from the header through the end of the gap
//   done            1-cycle pulse when the parity byte is consumed
//
// Optional build macro PARITY_CORRUPT_EN adds the input corrupt_parity.
// It is sampled with start. When set, the parity byte of that packet is
// inverted so the router error path can be exercised.
module router_pkt_tx #(
  parameter int DEPTH      = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       fifo_full,
  output logic [6:0] fifo_count,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
`ifdef PARITY_CORRUPT_EN
  input  logic       corrupt_parity,
`endif
  output logic       start_err,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int GW    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

  state_t state, state_n;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;
  logic             wr, pop;

  logic [7:0]    data_n, parity_reg, parity_n;
  logic          pv_n, ta_n, done_n, err_n, start_ok;
  logic [5:0]    remaining, rem_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          corrupt_q;

  function automatic logic [7:0] parity_byte(input logic [7:0] p, input logic inv);
    return inv ? ~p : p;
  endfunction

  // FIFO write side and occupancy; a pop is always backed by data because
  // a packet is only launched when all of its bytes are already queued.
  assign wr         = wr_en && !fifo_full;
  assign fifo_count = 7'(count);

  always_comb begin
    count_n = count;
    case ({wr, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  // Transmit FSM: next state and next registered outputs
  always_comb begin
    state_n  = state;
    data_n   = data_out;
    pv_n     = pkt_valid;
    ta_n     = tx_active;
    done_n   = 1'b0;
    err_n    = 1'b0;
    parity_n = parity_reg;
    rem_n    = remaining;
    gap_n    = gap_cnt;
    pop      = 1'b0;
    start_ok = (len != 6'd0) && (count >= CNT_W'(len));
    case (state)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_n  = HEADER;
            data_n   = {len, dest};
            pv_n     = 1'b1;
            ta_n     = 1'b1;
            parity_n = {len, dest};
            rem_n    = len;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HEADER, PAYLOAD: begin
        if (!busy) begin
          if (remaining != 6'd0) begin
            pop      = 1'b1;
            data_n   = mem[rd_ptr];
            parity_n = parity_reg ^ mem[rd_ptr];
            rem_n    = remaining - 6'd1;
            state_n  = PAYLOAD;
          end else begin
            state_n = PARITY;
            data_n  = parity_byte(parity_reg, corrupt_q);
            pv_n    = 1'b0;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          state_n = GAP;
          data_n  = 8'h00;
          done_n  = 1'b1;
          gap_n   = GW'(GAP_CYCLES);
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) begin
          state_n = IDLE;
          ta_n    = 1'b0;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Register stage: every output is a flop
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      data_out   <= 8'h00;
      pkt_valid  <= 1'b0;
      tx_active  <= 1'b0;
      done       <= 1'b0;
      start_err  <= 1'b0;
      parity_reg <= 8'h00;
      remaining  <= 6'd0;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
    end else begin
      state      <= state_n;
      data_out   <= data_n;
      pkt_valid  <= pv_n;
      tx_active  <= ta_n;
      done       <= done_n;
      start_err  <= err_n;
      parity_reg <= parity_n;
      remaining  <= rem_n;
      gap_cnt    <= gap_n;
      count      <= count_n;
      fifo_full  <= (count_n == CNT_W'(DEPTH));
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

`ifdef PARITY_CORRUPT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      corrupt_q <= 1'b0;
    end else if (state == IDLE && start && start_ok) begin
      corrupt_q <= corrupt_parity;
    end
  end
`else
  assign corrupt_q = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full;
  logic [6:0] fifo_count;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [5:0] len = 6'd0;
  logic       corrupt_parity = 1'b0;
  logic       start_err;
  logic       busy = 1'b0;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];   // {pkt_valid, data_out} per consumed byte
  logic [7:0] mfifo[$];   // bench model of FIFO contents
  logic       in_pkt = 1'b0;
  logic       done_due = 1'b0;

  router_pkt_tx dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .fifo_full(fifo_full),
    .fifo_count(fifo_count),
    .start(start),
    .dest(dest),
    .len(len),
`ifdef PARITY_CORRUPT_EN
    .corrupt_parity(corrupt_parity),
`endif
    .start_err(start_err),
    .busy(busy),
    .data_out(data_out),
    .pkt_valid(pkt_valid),
    .tx_active(tx_active),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a byte is consumed by the router
  always @(negedge clock) begin
    if (reset) begin
      in_pkt   = 1'b0;
      done_due = 1'b0;
    end else begin
      check("done_pulse", {31'd0, done}, {31'd0, done_due});
      done_due = 1'b0;
      if (tx_active && (pkt_valid || in_pkt) && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", {pkt_valid, data_out});
        end else begin
          check("tx_byte", {23'd0, pkt_valid, data_out}, {23'd0, exp_q.pop_front()});
        end
        if (pkt_valid) in_pkt = 1'b1;
        else begin
          in_pkt   = 1'b0;
          done_due = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (mfifo.size() < 64) mfifo.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [1:0] d, input logic [5:0] l, input logic cor);
    logic       ok;
    logic [7:0] p, b;
    ok = (l != 6'd0) && (mfifo.size() >= int'(l));
    if (ok) begin
      p = {l, d};
      exp_q.push_back({1'b1, p});
      for (int i = 0; i < int'(l); i++) begin
        b = mfifo.pop_front();
        p = p ^ b;
        exp_q.push_back({1'b1, b});
      end
      exp_q.push_back({1'b0, cor ? ~p : p});
    end
    dest = d; len = l; corrupt_parity = cor; start = 1'b1;
    tick();
    start = 1'b0; corrupt_parity = 1'b0;
    check("start_err", {31'd0, start_err}, {31'd0, !ok});
    check("hdr_valid", {31'd0, pkt_valid}, {31'd0, ok});
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!tx_active && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("pkt_drain", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    mfifo.delete();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_data_out", data_out, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_done", done, 0);
    check("rst_start_err", start_err, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_fifo_full", fifo_full, 0);

    // Basic packet: header 0x22, 0x01..0x08, parity 0x2A, gap of 2
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    check("count_8", fifo_count, 8);
    launch(2'd2, 6'd8, 1'b0);
    check("hdr_byte", data_out, 8'h22);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin found = 1'b1; break; end
    end
    check("done_seen", {31'd0, found}, 32'd1);
    check("gap_ta0", tx_active, 1);
    tick();
    check("gap_ta1", tx_active, 1);
    tick();
    check("gap_ta_end", tx_active, 0);
    wait_idle();
    check("fifo_empty", fifo_count, 0);

    // Busy stall on byte 0x03 for 3 cycles
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    launch(2'd2, 6'd8, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (data_out == 8'h03 && pkt_valid) begin found = 1'b1; break; end
      tick();
    end
    check("stall_found", {31'd0, found}, 32'd1);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", {23'd0, pkt_valid, data_out}, {23'd0, 9'h103});
    end
    busy = 1'b0;
    wait_idle();

    // Rejected starts: too few bytes, then zero length
    for (int i = 0; i < 5; i++) write_byte(8'(8'h10 + i));
    launch(2'd1, 6'd8, 1'b0);
    tick();
    check("rej_err_clear", start_err, 0);
    check("rej_pkt_valid", pkt_valid, 0);
    check("rej_count", fifo_count, 5);
    launch(2'd1, 6'd0, 1'b0);
    check("rej0_count", fifo_count, 5);
    launch(2'd1, 6'd5, 1'b0);
    check("hdr5_byte", data_out, 8'h15);
    wait_idle();

    // FIFO full and dropped write
    for (int i = 0; i < 64; i++) write_byte(8'(8'h40 + i));
    check("full_count", fifo_count, 64);
    check("full_flag", fifo_full, 1);
    write_byte(8'hEE);
    check("drop_count", fifo_count, 64);
    check("drop_full", fifo_full, 1);
    do_reset();
    check("clr_count", fifo_count, 0);
    check("clr_full", fifo_full, 0);

    // Reset during the 4th payload byte
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    launch(2'd2, 6'd8, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (data_out == 8'h04 && pkt_valid) begin found = 1'b1; break; end
      tick();
    end
    check("abort_found", {31'd0, found}, 32'd1);
    do_reset();
    check("abort_pkt_valid", pkt_valid, 0);
    check("abort_data_out", data_out, 0);
    check("abort_count", fifo_count, 0);
    check("abort_tx_active", tx_active, 0);
    tick();
    check("abort_idle", {30'd0, tx_active, pkt_valid}, 0);
    write_byte(8'hA0); write_byte(8'hA1); write_byte(8'hA2);
    launch(2'd3, 6'd3, 1'b0);
    check("hdr3_byte", data_out, 8'h0F);
    wait_idle();

`ifdef PARITY_CORRUPT_EN
    // Corrupted parity: 0x2A inverted is 0xD5
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    check("cor_model", {23'd0, exp_q.size() == 0}, 32'd1);
    launch(2'd2, 6'd8, 1'b1);
    check("cor_parity_exp", {23'd0, exp_q[exp_q.size()-1]}, {23'd0, 9'h0D5});
    wait_idle();
`endif

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source for the router input port. It is the transmitting end of the header/payload/parity byte protocol that the router register block receives.
- A host loads payload bytes into an internal FIFO, then issues a start command with destination and length.
- The block serialises header, payload and parity onto data_out/pkt_valid and honours the router's busy stall.

Parameters:
- DEPTH, 64, payload FIFO depth in bytes. Must be a power of 2 and at least 64 so a maximum 63-byte payload fits.
- GAP_CYCLES, 2, idle cycles forced between the parity byte and the next header.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe into payload FIFO
- wr_data  in  8  payload byte to write
- fifo_full  out  1  FIFO holds DEPTH bytes
- fifo_count  out  7  bytes currently in FIFO
- start  in  1  launch-packet request, 1-cycle pulse
- dest  in  2  destination address, sampled with start
- len  in  6  payload length 1..63, sampled with start
- start_err  out  1  1-cycle pulse: start rejected
- busy  in  1  router stall; current byte is not consumed while high
- data_out  out  8  byte to router
- pkt_valid  out  1  high during header and payload, low on parity
- tx_active  out  1  high from header through end of gap
- done  out  1  1-cycle pulse when the parity byte is consumed

Behaviour:
- Reset, synchronous, takes effect at the next edge:
  - data_out=0, pkt_valid=0, tx_active=0, done=0, start_err=0.
  - FIFO emptied (fifo_count=0, fifo_full=0); state=IDLE.
  - Reset mid-packet aborts the packet immediately; no parity byte is sent.
- All outputs are registered.
- Byte consumption rule: the byte on data_out is consumed at a rising edge where busy=0 and the state is HEADER, PAYLOAD or PARITY. While busy=1, data_out and pkt_valid hold.
- FIFO:
  - A write occurs when wr_en=1 and fifo_full=0. A write while full is dropped and fifo_count is unchanged.
  - A write and a pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - start=1 with len!=0 and fifo_count>=len: latch dest/len. Next edge: state=HEADER, data_out={len,dest}, pkt_valid=1, tx_active=1, parity_reg={len,dest}, remaining=len.
  - start=1 with len=0 or fifo_count<len: start_err=1 for one cycle; stay IDLE; FIFO untouched.
  - Start latency: header appears 1 clock after the start edge.
- HEADER/PAYLOAD, on consumption:
  - If remaining>0: pop FIFO into data_out, parity_reg ^= popped byte, remaining--; state=PAYLOAD.
  - If remaining=0: state=PARITY, data_out=parity_reg, pkt_valid=0.
- PARITY, on consumption: state=GAP, data_out=0, done=1 for one cycle, gap counter loaded with GAP_CYCLES.
- GAP: counts down; when it reaches 0, state=IDLE and tx_active=0. start in GAP or any non-IDLE state is ignored, with no start_err.
- Packet length: a packet occupies exactly len+2 consumed bytes; with busy=0 throughout, pkt_valid is high for len+1 consecutive cycles.
- Bytes written during a packet are queued behind the packet's bytes. Ordering is strict FIFO.

Optional Feature:
- Macro PARITY_CORRUPT_EN.
- When defined: adds input corrupt_parity (1 bit), sampled with start. If set, the parity byte sent is the bitwise inverse of the correct parity, for router error-path testing.
- When undefined: the port is absent and parity is always correct.

Test Plan:
- Write 0x01..0x08, start dest=2 len=8, busy=0:
  - Header 0x22, then 0x01..0x08 with pkt_valid=1 for 9 cycles.
  - Then parity 0x2A with pkt_valid=0, done pulse, tx_active low after 2 gap cycles.
- Same packet with busy=1 for 3 cycles while 0x03 is on data_out: 0x03 holds 4 cycles, pkt_valid stays 1, the remaining sequence is unchanged and parity is 0x2A.
- Rejected starts:
  - 5 bytes loaded, start len=8 -> start_err pulse, pkt_valid stays 0, fifo_count stays 5.
  - start len=0 -> start_err pulse.
- Write 64 bytes -> fifo_full=1, fifo_count=64; a 65th write is dropped and the count stays 64.
- Assert reset during the 4th payload byte -> next edge pkt_valid=0, data_out=0, fifo_count=0, state IDLE; a subsequent normal packet is correct.
- PARITY_CORRUPT_EN: first scenario with corrupt_parity=1 -> parity byte 0xD5.
